// File: rtl/sample_splitter.sv
// Serializes 16-bit samples into a byte stream for the UART transmitter.
// A small sample FIFO absorbs UART backpressure; dropped samples set a sticky flag.
module sample_splitter #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [7:0]       data_uart_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             full_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    // Handshake: a byte transfers on a rising edge where valid_o and ready_i
    // are both high; once raised, valid_o and data_uart_o hold until then.
    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             wr_en, pop, empty;
    logic [WIDTH-1:0] head;

    function automatic logic [7:0] first_byte(input logic [15:0] s);
        return MSB_FIRST ? s[15:8] : s[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] s);
        return MSB_FIRST ? s[7:0] : s[15:8];
    endfunction

    assign empty = (count_q == '0);
    assign full_o = (count_q == CW'(DEPTH));
    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign wr_en = valid_i && !full_o;
    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = first_byte(head);
                    valid_d = 1'b1;
                    state_d = BYTE0;
                end
            end
            BYTE0: begin
                if (ready_i) begin
                    byte_d  = second_byte(hold_q);
                    state_d = BYTE1;
                end
            end
            BYTE1: begin
                if (ready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        byte_d  = first_byte(head);
                        state_d = BYTE0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            if (pop) begin
                hold_q   <= head;
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (valid_i && full_o) begin
                ovf_q <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_uart_o = byte_q;
    assign valid_o     = valid_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_sample_splitter.sv
// Bench for sample_splitter: directed vectors plus randomized traffic checked
// against a queue-based model of the sample and byte streams.
module tb_sample_splitter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_i;
    logic [7:0]  data_uart_o, data_uart_l;
    logic        valid_o, valid_l;
    logic        full_o, full_l;
    logic        overflow_o, overflow_l;
    logic        busy_o, busy_l;

    int n_checks = 0;
    int n_errors = 0;

    sample_splitter #(.WIDTH(16), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .data_uart_o(data_uart_o), .valid_o(valid_o), .ready_i(ready_i),
        .full_o(full_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    sample_splitter #(.WIDTH(16), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .data_uart_o(data_uart_l), .valid_o(valid_l), .ready_i(ready_i),
        .full_o(full_l), .overflow_o(overflow_l), .busy_o(busy_l)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: FIFO of samples, one sample in flight with bytes remaining
    logic [15:0] fifo_m[$];
    logic [15:0] hold_m;
    int          rem_m;
    logic        ovf_m;

    function automatic logic [7:0] model_byte(input bit msb_first);
        logic [15:0] s;
        s = hold_m;
        if (msb_first) return (rem_m == 2) ? s[15:8] : s[7:0];
        else           return (rem_m == 2) ? s[7:0]  : s[15:8];
    endfunction

    initial begin
        fifo_m.delete();
        hold_m = '0;
        rem_m  = 0;
        ovf_m  = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            fifo_m.delete();
            rem_m = 0;
            ovf_m = 1'b0;
            chk("rst_valid", {15'd0, valid_o}, 16'd0);
            chk("rst_byte", {8'd0, data_uart_o}, 16'd0);
            chk("rst_full", {15'd0, full_o}, 16'd0);
            chk("rst_ovf", {15'd0, overflow_o}, 16'd0);
            chk("rst_busy", {15'd0, busy_o}, 16'd0);
            chk("rst_valid_lsb", {15'd0, valid_l}, 16'd0);
        end else begin
            chk("m_valid", {15'd0, valid_o}, {15'd0, rem_m != 0});
            chk("m_valid_lsb", {15'd0, valid_l}, {15'd0, rem_m != 0});
            if (rem_m != 0) begin
                chk("m_byte", {8'd0, data_uart_o}, {8'd0, model_byte(1'b1)});
                chk("m_byte_lsb", {8'd0, data_uart_l}, {8'd0, model_byte(1'b0)});
            end
            chk("m_full", {15'd0, full_o}, {15'd0, fifo_m.size() == DEPTH});
            chk("m_ovf", {15'd0, overflow_o}, {15'd0, ovf_m});
            chk("m_busy", {15'd0, busy_o}, {15'd0, (rem_m != 0) || (fifo_m.size() != 0)});
            chk("m_busy_lsb", {15'd0, busy_l}, {15'd0, (rem_m != 0) || (fifo_m.size() != 0)});
            // advance to the state after the coming rising edge
            begin
                bit wr_ok;
                wr_ok = valid_i && (fifo_m.size() < DEPTH);
                if (valid_i && !wr_ok) ovf_m = 1'b1;
                if (rem_m != 0 && ready_i) rem_m--;
                if (rem_m == 0 && fifo_m.size() > 0) begin
                    hold_m = fifo_m.pop_front();
                    rem_m  = 2;
                end
                if (wr_ok) fifo_m.push_back(data_i);
            end
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vecs[5];
    logic [15:0] b2b[3];
    logic [7:0]  b2b_exp[6];

    initial begin
        vecs[0] = '{16'h8001, 8'h80, 8'h01};
        vecs[1] = '{16'hBEEF, 8'hBE, 8'hEF};
        vecs[2] = '{16'h0000, 8'h00, 8'h00};
        vecs[3] = '{16'h7FFF, 8'h7F, 8'hFF};
        vecs[4] = '{16'h1234, 8'h12, 8'h34};
        b2b[0] = 16'h1234; b2b[1] = 16'hABCD; b2b[2] = 16'hFFFF;
        b2b_exp[0] = 8'h12; b2b_exp[1] = 8'h34; b2b_exp[2] = 8'hAB;
        b2b_exp[3] = 8'hCD; b2b_exp[4] = 8'hFF; b2b_exp[5] = 8'hFF;

        rst = 1'b1;
        data_i = '0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("reset_valid", {15'd0, valid_o}, 16'd0);
        chk("reset_busy", {15'd0, busy_o}, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // single samples through both byte orders
        for (int i = 0; i < 5; i++) begin
            ready_i = 1'b1;
            valid_i = 1'b1;
            data_i  = vecs[i].data;
            tick();
            valid_i = 1'b0;
            chk("tbl_no_valid_at_write", {15'd0, valid_o}, 16'd0);
            chk("tbl_busy_at_write", {15'd0, busy_o}, 16'd1);
            tick();
            chk("tbl_valid0", {15'd0, valid_o}, 16'd1);
            chk("tbl_b0_msb", {8'd0, data_uart_o}, {8'd0, vecs[i].hi});
            chk("tbl_b0_lsb", {8'd0, data_uart_l}, {8'd0, vecs[i].lo});
            tick();
            chk("tbl_valid1", {15'd0, valid_o}, 16'd1);
            chk("tbl_b1_msb", {8'd0, data_uart_o}, {8'd0, vecs[i].lo});
            chk("tbl_b1_lsb", {8'd0, data_uart_l}, {8'd0, vecs[i].hi});
            tick();
            chk("tbl_valid_end", {15'd0, valid_o}, 16'd0);
            chk("tbl_busy_end", {15'd0, busy_o}, 16'd0);
        end

        // stalls in both byte phases
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 16'h8001;
        tick();
        valid_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_b0_valid", {15'd0, valid_o}, 16'd1);
            chk("stall_b0_byte", {8'd0, data_uart_o}, 16'h0080);
            ready_i = (i == 3);
            tick();
        end
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_b1_valid", {15'd0, valid_o}, 16'd1);
            chk("stall_b1_byte", {8'd0, data_uart_o}, 16'h0001);
            ready_i = (i == 2);
            tick();
        end
        chk("stall_done", {15'd0, valid_o}, 16'd0);

        // back-to-back samples, continuous byte stream
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            valid_i = (c < 3);
            data_i  = (c < 3) ? b2b[c] : 16'h0;
            tick();
            if (c >= 1 && c <= 6) begin
                chk("b2b_valid", {15'd0, valid_o}, 16'd1);
                chk("b2b_byte", {8'd0, data_uart_o}, {8'd0, b2b_exp[c-1]});
            end else if (c == 7) begin
                chk("b2b_end", {15'd0, valid_o}, 16'd0);
            end
        end
        valid_i = 1'b0;

        // capacity and overflow
        ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            valid_i = 1'b1;
            data_i  = 16'(c + 1);
            tick();
            if (c == 4) chk("ovf_not_yet", {15'd0, overflow_o}, 16'd0);
        end
        valid_i = 1'b0;
        chk("ovf_full", {15'd0, full_o}, 16'd1);
        chk("ovf_set", {15'd0, overflow_o}, 16'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("ovf_drain_valid", {15'd0, valid_o}, 16'd1);
            chk("ovf_drain_byte", {8'd0, data_uart_o}, (i % 2 == 0) ? 16'h0 : 16'(i / 2 + 1));
            tick();
        end
        chk("ovf_drain_end", {15'd0, valid_o}, 16'd0);
        chk("ovf_sticky", {15'd0, overflow_o}, 16'd1);

        // asynchronous reset while in the second byte with two samples queued
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 16'h1111; tick();
        data_i = 16'h2222; tick();
        data_i = 16'h3333; tick();
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("pre_rst_byte", {8'd0, data_uart_o}, 16'h0011);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {15'd0, valid_o}, 16'd0);
        chk("async_byte", {8'd0, data_uart_o}, 16'd0);
        chk("async_full", {15'd0, full_o}, 16'd0);
        chk("async_ovf", {15'd0, overflow_o}, 16'd0);
        chk("async_busy", {15'd0, busy_o}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_quiet", {15'd0, valid_o}, 16'd0);
        end
        valid_i = 1'b1; data_i = 16'h5A5A; tick();
        valid_i = 1'b0; tick();
        chk("post_rst_new", {8'd0, data_uart_o}, 16'h005A);
        tick(); tick();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            valid_i = ($urandom_range(0, 99) < 40);
            data_i  = 16'($urandom);
            ready_i = ($urandom_range(0, 99) < 55);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (20) tick();
        chk("final_idle", {15'd0, busy_o}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
